// File: rtl/reg_16bit_down.sv
// Loadable down-counting register with terminal-count pulse and optional
// auto-reload of the last loaded value.
module reg_16bit_down #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             load,
    input  logic             decr,
    input  logic [WIDTH-1:0] load_input,
    input  logic             reload_en,
    output logic [WIDTH-1:0] A,
    output logic             zero,
    output logic             underflow,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE,
        COUNT,
        EXPIRED
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] a_next;
    logic [WIDTH-1:0] reload_val;
    logic [WIDTH-1:0] reload_next;
    logic             underflow_next;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state      <= IDLE;
            A          <= '0;
            reload_val <= '0;
            underflow  <= 1'b0;
        end else begin
            state      <= state_next;
            A          <= a_next;
            reload_val <= reload_next;
            underflow  <= underflow_next;
        end
    end

    // Load beats decrement; outside COUNT the count is frozen at zero.
    always_comb begin
        state_next     = state;
        a_next         = A;
        reload_next    = reload_val;
        underflow_next = 1'b0;
        if (load) begin
            a_next      = load_input;
            reload_next = load_input;
            state_next  = (load_input != '0) ? COUNT : IDLE;
        end else begin
            unique case (state)
                COUNT: begin
                    if (decr) begin
                        if (A == WIDTH'(1)) begin
                            underflow_next = 1'b1;
                            if (reload_en) begin
                                a_next = reload_val;
                            end else begin
                                a_next     = '0;
                                state_next = EXPIRED;
                            end
                        end else begin
                            a_next = A - WIDTH'(1);
                        end
                    end
                end
                IDLE, EXPIRED: begin
                    state_next = state;
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    assign zero = (A == '0);
    assign busy = (state == COUNT);

endmodule

// File: tb/tb_reg_16bit_down.sv
// Bench for reg_16bit_down: directed vector table, reset corner cases and a
// randomized run against a behavioural count model.
module tb_reg_16bit_down;

    logic        clk;
    logic        clr_n;
    logic        load;
    logic        decr;
    logic [15:0] load_input;
    logic        reload_en;
    logic [15:0] A;
    logic        zero;
    logic        underflow;
    logic        busy;

    int total;
    int bad;

    // Behavioural model: a count, the last loaded value, and whether counting.
    logic [15:0] m_count;
    logic [15:0] m_last;
    logic        m_running;
    logic        m_pulse;

    typedef struct {
        logic        ld;
        logic        dc;
        logic [15:0] li;
        logic        re;
        logic [15:0] exp_a;
        logic        exp_uf;
        logic        exp_busy;
    } vec_t;

    vec_t vecs[$];

    reg_16bit_down #(.WIDTH(16)) dut (
        .clk        (clk),
        .clr_n      (clr_n),
        .load       (load),
        .decr       (decr),
        .load_input (load_input),
        .reload_en  (reload_en),
        .A          (A),
        .zero       (zero),
        .underflow  (underflow),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkAll(input string tag, input logic [15:0] ea, input logic eu, input logic eb);
        checkOutput({tag, ".A"}, A, ea);
        checkOutput({tag, ".zero"}, {15'd0, zero}, {15'd0, (ea == 16'd0)});
        checkOutput({tag, ".underflow"}, {15'd0, underflow}, {15'd0, eu});
        checkOutput({tag, ".busy"}, {15'd0, busy}, {15'd0, eb});
    endtask

    task automatic modelReset();
        m_count   = 16'd0;
        m_last    = 16'd0;
        m_running = 1'b0;
        m_pulse   = 1'b0;
    endtask

    // Drive one cycle of inputs, advance one edge, and step the model.
    task automatic applyStimulus(input logic ld, input logic dc, input logic [15:0] li, input logic re);
        load       = ld;
        decr       = dc;
        load_input = li;
        reload_en  = re;
        @(posedge clk);
        #1;
        m_pulse = 1'b0;
        if (ld) begin
            m_count   = li;
            m_last    = li;
            m_running = (li != 16'd0);
        end else if (m_running && dc) begin
            if (m_count == 16'd1) begin
                m_pulse = 1'b1;
                if (re) m_count = m_last;
                else begin
                    m_count   = 16'd0;
                    m_running = 1'b0;
                end
            end else begin
                m_count = m_count - 16'd1;
            end
        end
    endtask

    task automatic addVec(input logic ld, input logic dc, input logic [15:0] li, input logic re,
                          input logic [15:0] ea, input logic eu, input logic eb);
        vec_t v;
        v.ld = ld; v.dc = dc; v.li = li; v.re = re;
        v.exp_a = ea; v.exp_uf = eu; v.exp_busy = eb;
        vecs.push_back(v);
    endtask

    task automatic doReset();
        #2;
        clr_n = 1'b0;
        #1;
        modelReset();
        checkAll("reset", 16'd0, 1'b0, 1'b0);
        #2;
        clr_n = 1'b1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        clr_n = 1'b1;
        load = 0; decr = 0; load_input = 0; reload_en = 0;
        modelReset();

        // Basic countdown, then decrements ignored while expired
        addVec(1, 0, 16'h0003, 0, 16'h0003, 0, 1);
        addVec(0, 1, 16'h0000, 0, 16'h0002, 0, 1);
        addVec(0, 1, 16'h0000, 0, 16'h0001, 0, 1);
        addVec(0, 1, 16'h0000, 0, 16'h0000, 1, 0);
        addVec(0, 1, 16'h0000, 0, 16'h0000, 0, 0);
        addVec(0, 1, 16'h0000, 1, 16'h0000, 0, 0);
        // Auto-reload with period 2
        addVec(1, 0, 16'h0002, 1, 16'h0002, 0, 1);
        addVec(0, 1, 16'h0000, 1, 16'h0001, 0, 1);
        addVec(0, 1, 16'h0000, 1, 16'h0002, 1, 1);
        addVec(0, 1, 16'h0000, 1, 16'h0001, 0, 1);
        addVec(0, 1, 16'h0000, 1, 16'h0002, 1, 1);
        addVec(0, 1, 16'h0000, 1, 16'h0001, 0, 1);
        addVec(0, 1, 16'h0000, 1, 16'h0002, 1, 1);
        // Load wins over a terminal decrement
        addVec(0, 1, 16'h0000, 0, 16'h0001, 0, 1);
        addVec(1, 1, 16'h00AA, 0, 16'h00AA, 0, 1);
        addVec(1, 1, 16'h0000, 0, 16'h0000, 0, 0);
        addVec(0, 1, 16'h0000, 0, 16'h0000, 0, 0);
        // Hold and large values
        addVec(1, 0, 16'hFFFF, 0, 16'hFFFF, 0, 1);
        addVec(0, 1, 16'h0000, 0, 16'hFFFE, 0, 1);
        addVec(0, 0, 16'h0000, 0, 16'hFFFE, 0, 1);
        addVec(0, 1, 16'h0000, 0, 16'hFFFD, 0, 1);
        addVec(0, 0, 16'h1234, 1, 16'hFFFD, 0, 1);
        addVec(0, 1, 16'h0000, 0, 16'hFFFC, 0, 1);
        // Reload value of 1: back-to-back pulses
        addVec(1, 0, 16'h0001, 1, 16'h0001, 0, 1);
        addVec(0, 1, 16'h0000, 1, 16'h0001, 1, 1);
        addVec(0, 1, 16'h0000, 1, 16'h0001, 1, 1);
        addVec(0, 0, 16'h0000, 1, 16'h0001, 0, 1);

        @(posedge clk);
        doReset();

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].ld, vecs[i].dc, vecs[i].li, vecs[i].re);
            checkAll($sformatf("vec%0d", i), vecs[i].exp_a, vecs[i].exp_uf, vecs[i].exp_busy);
        end

        // Reset while underflow is high clears it with no edge
        applyStimulus(1, 0, 16'h0001, 1);
        applyStimulus(0, 1, 16'h0000, 1);
        checkAll("pulse_before_reset", 16'h0001, 1'b1, 1'b1);
        doReset();

        // Reset mid-count, then decrements do nothing until a load
        applyStimulus(1, 0, 16'h0010, 0);
        for (int k = 0; k < 5; k++) applyStimulus(0, 1, 16'h0000, 0);
        checkAll("midcount", 16'h000B, 1'b0, 1'b1);
        doReset();
        for (int k = 0; k < 3; k++) begin
            applyStimulus(0, 1, 16'h0000, k[0]);
            checkAll("after_reset", 16'h0000, 1'b0, 1'b0);
        end
        applyStimulus(1, 0, 16'h0004, 0);
        checkAll("reload_after_reset", 16'h0004, 1'b0, 1'b1);

        // Randomized run against the model
        for (int k = 0; k < 400; k++) begin
            logic        r_ld;
            logic [15:0] r_li;
            r_ld = ($urandom_range(0, 11) == 0);
            r_li = ($urandom_range(0, 7) == 0) ? 16'($urandom) : 16'($urandom_range(0, 6));
            applyStimulus(r_ld, ($urandom_range(0, 3) != 0), r_li, 1'($urandom));
            checkAll("rand", m_count, m_pulse, m_running);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/reg_16bit_down.md
# reg_16bit_down

Loadable down-counting register, the decrement-direction counterpart of the team's 16-bit load/increment register. Holds a value loaded from the datapath, counts it down one step per `decr` strobe, flags terminal count with a one-cycle `underflow` pulse, and can optionally auto-reload the last loaded value. It is the delay/loop-count register beside the accumulator and program-counter registers in the datapath.

## Interface
- `WIDTH`, 16, register width in bits.
- `clk`  input  1  rising-edge clock.
- `clr_n`  input  1  asynchronous active-low reset.
- `load`  input  1  load `load_input` into `A` and into the reload shadow.
- `decr`  input  1  decrement strobe, one step per cycle while high.
- `load_input`  input  WIDTH  value to load.
- `reload_en`  input  1  at terminal count, reload the shadow value instead of stopping.
- `A`  output  WIDTH  current count.
- `zero`  output  1  high when `A == 0`; combinational from the `A` register.
- `underflow`  output  1  registered one-cycle pulse on the terminal decrement.
- `busy`  output  1  high in state COUNT.

## Operation
- State register with three states: IDLE, COUNT, EXPIRED. Internal WIDTH-bit shadow register `reload_val`.
- Reset (`clr_n` low, asynchronous, any time): `A`=0, `reload_val`=0, state=IDLE, `underflow`=0. So `busy`=0 and `zero`=1. Reset mid-count aborts immediately with no underflow pulse.
- Priority at each edge: `load` over `decr`. `load` is accepted in every state.
- `load`: `A`<=`load_input`, `reload_val`<=`load_input`, `underflow`<=0. Next state is COUNT if `load_input` != 0, otherwise IDLE.
- COUNT with `decr` and `A` > 1: `A`<=`A`-1, stay in COUNT.
- COUNT with `decr` and `A` == 1 (terminal decrement): `underflow`<=1.
  - If `reload_en`=0: `A`<=0 and the next state is EXPIRED.
  - If `reload_en`=1: `A`<=`reload_val`, stay in COUNT. `A` never shows 0 in this case.
  - `reload_en` is sampled only on the terminal-decrement edge.
- COUNT without `decr`: hold `A`.
- IDLE and EXPIRED: `decr` is ignored and `A` holds 0. Only `load` leaves these states; reset also returns to IDLE.
- `underflow` is 0 on every edge that is not a terminal decrement, so it pulses for exactly one cycle. Back-to-back pulses are legal when reload is enabled with `reload_val`=1.
- Arithmetic: unsigned, modulo 2^WIDTH. A decrement below 0 is structurally impossible, because COUNT implies `A` >= 1.
- `load` and `decr` together: the load wins, the decrement is dropped and no underflow occurs, even if `A` == 1.

## Timing
- All state changes occur on the rising `clk` edge, except reset.
- Latency is one edge:
  - After `load`, `A` is visible in the next cycle.
  - Each accepted `decr` cycle changes `A` after one edge.
  - `underflow` and the state change coincide with the edge on which `A` becomes 0 or is reloaded.
- `zero` follows `A` in the same cycle, with no extra register.
- An N loaded into COUNT with `decr` held high reaches terminal count after N edges. With reload enabled, the reload period is N cycles.
- Inputs are synchronous to `clk`. There is no handshake: `decr` is a level, sampled every edge.

## Test plan
- Reset: pulse `clr_n` low between clock edges -> `A`=0, `zero`=1, `busy`=0 and `underflow`=0 immediately, with no clock edge needed.
- Basic countdown: load 16'h0003, then hold `decr` for 4 cycles with `reload_en`=0 -> `A` goes 3,2,1,0; `underflow` is high only in the cycle `A` becomes 0; the state goes to EXPIRED; the 4th `decr` leaves `A`=0 with no further pulse.
- Auto-reload: load 16'h0002 with `reload_en`=1 and `decr` held for 6 cycles -> `A` goes 2,1,2,1,2,1; `underflow` pulses on cycles 2, 4 and 6; `busy` stays 1 and `zero` is never 1.
- Load priority: with `A`=1 in COUNT, assert `load`=1 with `load_input`=16'h00AA together with `decr` -> `A`=16'h00AA and `underflow`=0. Load 16'h0000 -> state IDLE and `busy`=0.
- Hold and wrap: load 16'hFFFF, toggle `decr` every other cycle -> `A` decrements only on strobe cycles (FFFE, FFFD, ...) and holds otherwise.
- Reset mid-count: load 16'h0010, decrement 5 times, assert `clr_n` low -> `A`=0 at once, state IDLE, no `underflow`. After release, `decr` has no effect until the next `load`.
